// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : MIPS memory-access pipeline stage; waits for the load response,
//            extracts/extends loaded data, forwards results to decode and
//            discards responses that belong to flushed instructions.
//            Optional build macro: MS_LOAD_FWD_EN (forward load data in the
//            data_ok cycle instead of one cycle later).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int EXB_WD = 80
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                es_to_ms_valid,
    output logic                ms_allowin,
    input  logic [EXB_WD+77:0]  es_to_ms_bus,
    input  logic                ws_allowin,
    output logic                ms_to_ws_valid,
    output logic [EXB_WD+69:0]  ms_to_ws_bus,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                ws_ex,
    output logic                ms_fwd_valid,
    output logic [4:0]          ms_fwd_dest,
    output logic [31:0]         ms_fwd_data,
    output logic                ms_load_wait
);

    // The packed fields occupy the low EXB_WD+77 bits; the top bit is spare.
    localparam int BUS_WD = EXB_WD + 77;

    logic              r_ms_valid;
    logic [BUS_WD-1:0] r_ms_bus;
    logic              r_data_rcvd;
    logic [31:0]       r_rdata;
    logic [1:0]        r_discard_cnt;

    logic [EXB_WD-1:0] w_exb;
    logic              w_mem_req;
    logic              w_res_from_mem;
    logic              w_ld_sign;
    logic [1:0]        w_ld_size;
    logic [1:0]        w_addr_low;
    logic              w_gr_we;
    logic [4:0]        w_dest;
    logic [31:0]       w_alu_result;
    logic [31:0]       w_pc;
    logic              w_unused_spare;

    logic              w_resp_hit;
    logic              w_drop;
    logic              w_flush_inc;
    logic              w_ready_go;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_final_result;

    assign w_pc           = r_ms_bus[31:0];
    assign w_alu_result   = r_ms_bus[63:32];
    assign w_dest         = r_ms_bus[68:64];
    assign w_gr_we        = r_ms_bus[69];
    assign w_addr_low     = r_ms_bus[71:70];
    assign w_ld_size      = r_ms_bus[73:72];
    assign w_ld_sign      = r_ms_bus[74];
    assign w_res_from_mem = r_ms_bus[75];
    assign w_mem_req      = r_ms_bus[76];
    assign w_exb          = r_ms_bus[BUS_WD-1:77];
    assign w_unused_spare = es_to_ms_bus[EXB_WD+77];

    function automatic logic [31:0] ld_extract(
        input logic [31:0] d,
        input logic [1:0]  size,
        input logic [1:0]  alow,
        input logic        sgn
    );
        logic [31:0] sh;
        logic [15:0] h;
        sh = d >> {alow, 3'b000};
        h  = alow[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   ld_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   ld_extract = {{16{sgn & h[15]}}, h};
            default: ld_extract = d;
        endcase
    endfunction

    // A response is ours only once every older flushed response has drained.
    assign w_resp_hit  = data_sram_data_ok && (r_discard_cnt == 2'd0) && r_ms_valid
                         && w_mem_req && !r_data_rcvd;
    assign w_drop      = data_sram_data_ok && (r_discard_cnt != 2'd0);
    assign w_flush_inc = ws_ex && r_ms_valid && w_mem_req && !r_data_rcvd && !w_resp_hit;

    assign w_ready_go     = !w_mem_req || r_data_rcvd || w_resp_hit;
    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;

    assign w_ld_data      = w_resp_hit ? data_sram_rdata : r_rdata;
    assign w_final_result = w_res_from_mem
                            ? ld_extract(w_ld_data, w_ld_size, w_addr_low, w_ld_sign)
                            : w_alu_result;

    assign ms_to_ws_bus = {w_exb, w_gr_we, w_dest, w_final_result, w_pc};
    assign ms_fwd_dest  = (r_ms_valid && w_gr_we) ? w_dest : 5'd0;

`ifdef MS_LOAD_FWD_EN
    assign ms_fwd_valid = r_ms_valid && w_gr_we && (!w_res_from_mem || r_data_rcvd || w_resp_hit);
    assign ms_fwd_data  = w_final_result;
    assign ms_load_wait = r_ms_valid && w_res_from_mem && !r_data_rcvd && !w_resp_hit;
`else
    assign ms_fwd_valid = r_ms_valid && w_gr_we && (!w_res_from_mem || r_data_rcvd);
    assign ms_fwd_data  = w_res_from_mem
                          ? ld_extract(r_rdata, w_ld_size, w_addr_low, w_ld_sign)
                          : w_alu_result;
    assign ms_load_wait = r_ms_valid && w_res_from_mem && !r_data_rcvd;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ms_valid    <= 1'b0;
            r_ms_bus      <= '0;
            r_data_rcvd   <= 1'b0;
            r_rdata       <= 32'd0;
            r_discard_cnt <= 2'd0;
        end else begin
            if (ws_ex) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end

            if (es_to_ms_valid && ms_allowin && !ws_ex) begin
                r_ms_bus <= es_to_ms_bus[BUS_WD-1:0];
            end

            if (ws_ex || ms_allowin) begin
                r_data_rcvd <= 1'b0;
            end else if (w_resp_hit) begin
                r_data_rcvd <= 1'b1;
            end

            if (w_resp_hit) begin
                r_rdata <= data_sram_rdata;
            end

            // Flush of a pending access and drop of a stale response cancel out.
            case ({w_flush_inc, w_drop})
                2'b10: if (r_discard_cnt != 2'd3) r_discard_cnt <= r_discard_cnt + 2'd1;
                2'b01: r_discard_cnt <= r_discard_cnt - 2'd1;
                default: r_discard_cnt <= r_discard_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage (vector table plus directed
//            multi-cycle sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam int EXB_WD = 80;

    logic                clk = 1'b0;
    logic                resetn;
    logic                es_to_ms_valid;
    logic                ms_allowin;
    logic [EXB_WD+77:0]  es_to_ms_bus;
    logic                ws_allowin;
    logic                ms_to_ws_valid;
    logic [EXB_WD+69:0]  ms_to_ws_bus;
    logic                data_sram_data_ok;
    logic [31:0]         data_sram_rdata;
    logic                ws_ex;
    logic                ms_fwd_valid;
    logic [4:0]          ms_fwd_dest;
    logic [31:0]         ms_fwd_data;
    logic                ms_load_wait;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef MS_LOAD_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    mem_stage #(.EXB_WD(EXB_WD)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_ex             (ws_ex),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_data       (ms_fwd_data),
        .ms_load_wait      (ms_load_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem_req;
        logic        rfm;
        logic        sgn;
        logic [1:0]  size;
        logic [1:0]  alow;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [EXB_WD+77:0] mk_bus(
        input logic [EXB_WD-1:0] exb, input logic mreq, input logic rfm,
        input logic sgn, input logic [1:0] size, input logic [1:0] alow,
        input logic we, input logic [4:0] dest, input logic [31:0] alu,
        input logic [31:0] pc
    );
        mk_bus = {1'b0, exb, mreq, rfm, sgn, size, alow, we, dest, alu, pc};
    endfunction

    function automatic logic [EXB_WD+69:0] mk_out(
        input logic [EXB_WD-1:0] exb, input logic we, input logic [4:0] dest,
        input logic [31:0] res, input logic [31:0] pc
    );
        mk_out = {exb, we, dest, res, pc};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [EXB_WD+77:0] b);
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
    endtask

    function automatic logic [EXB_WD-1:0] exb_of(input int k);
        exb_of = {EXB_WD{1'b0}} | (80'hA5A5_0000_0000_0000_0000 + EXB_WD'(k));
    endfunction

    initial begin
        // mem_req rfm sgn size alow we dest alu rdata expected
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b1, 5'd5,  32'h12345678, 32'h0,        32'h12345678};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'b00, 2'd2, 1'b1, 5'd6,  32'h0,        32'h00800000, 32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 2'd2, 1'b1, 5'd7,  32'h0,        32'h00800000, 32'h00000080};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'b01, 2'd2, 1'b1, 5'd8,  32'h0,        32'h80010000, 32'h00008001};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'b01, 2'd2, 1'b1, 5'd9,  32'h0,        32'h80010000, 32'hFFFF8001};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b01, 2'd0, 1'b1, 5'd10, 32'h0,        32'h12347FFF, 32'h00007FFF};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'b00, 2'd3, 1'b1, 5'd11, 32'h0,        32'h7F000000, 32'h0000007F};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'b00, 2'd0, 1'b1, 5'd12, 32'h0,        32'h000000FF, 32'hFFFFFFFF};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'b10, 2'd0, 1'b1, 5'd13, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b10, 2'd0, 1'b0, 5'd14, 32'h00001000, 32'h55555555, 32'h00001000};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 2'b00, 2'd1, 1'b1, 5'd15, 32'h0,        32'h0000AB00, 32'h000000AB};

        resetn = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; ws_ex = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_allowin",   ms_allowin, 1);
        chk("rst_to_ws_vld", ms_to_ws_valid, 0);
        chk("rst_fwd_vld",   ms_fwd_valid, 0);
        chk("rst_fwd_dest",  ms_fwd_dest, 0);
        chk("rst_load_wait", ms_load_wait, 0);

        // Table: response arrives in the first MS cycle, WB always accepting.
        for (int i = 0; i < 11; i++) begin
            issue(mk_bus(exb_of(i), tbl[i].mem_req, tbl[i].rfm, tbl[i].sgn, tbl[i].size,
                         tbl[i].alow, tbl[i].gr_we, tbl[i].dest, tbl[i].alu, 32'h1000 + 32'(i*4)));
            data_sram_data_ok = 1'b0;
            @(negedge clk);
            es_to_ms_valid    = 1'b0;
            data_sram_data_ok = tbl[i].mem_req;
            data_sram_rdata   = tbl[i].rdata;
            #1;
            chk($sformatf("vec%0d_valid", i), ms_to_ws_valid, 1);
            chk($sformatf("vec%0d_bus", i), ms_to_ws_bus,
                mk_out(exb_of(i), tbl[i].gr_we, tbl[i].dest, tbl[i].exp, 32'h1000 + 32'(i*4)));
            chk($sformatf("vec%0d_fwd_dest", i), ms_fwd_dest, tbl[i].gr_we ? tbl[i].dest : 5'd0);
        end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("tbl_drain_valid", ms_to_ws_valid, 0);

        // LB with response three cycles late.
        issue(mk_bus(exb_of(20), 1, 1, 1, 2'b00, 2'd2, 1, 5'd3, 32'h0, 32'h100));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b0;
            #1;
            chk($sformatf("lb_wait%0d_load_wait", c), ms_load_wait, 1);
            chk($sformatf("lb_wait%0d_valid", c), ms_to_ws_valid, 0);
            chk($sformatf("lb_wait%0d_allowin", c), ms_allowin, 0);
        end
        @(negedge clk);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h00800000;
        #1;
        chk("lb_resp_valid", ms_to_ws_valid, 1);
        chk("lb_resp_bus", ms_to_ws_bus, mk_out(exb_of(20), 1, 5'd3, 32'hFFFFFF80, 32'h100));
        chk("lb_resp_load_wait", ms_load_wait, !FWD_ON);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("lb_after_valid", ms_to_ws_valid, 0);

        // LW with WB back-pressure for two cycles.
        issue(mk_bus(exb_of(30), 1, 1, 0, 2'b10, 2'd0, 1, 5'd4, 32'h0, 32'h500));
        @(negedge clk);
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF;
        #1;
        chk("lw_hold0_valid", ms_to_ws_valid, 1);
        chk("lw_hold0_bus", ms_to_ws_bus, mk_out(exb_of(30), 1, 5'd4, 32'hDEADBEEF, 32'h500));
        chk("lw_hold0_fwd_valid", ms_fwd_valid, FWD_ON);
        if (FWD_ON) chk("lw_hold0_fwd_data", ms_fwd_data, 32'hDEADBEEF);
        @(negedge clk);
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        #1;
        chk("lw_hold1_valid", ms_to_ws_valid, 1);
        chk("lw_hold1_bus", ms_to_ws_bus, mk_out(exb_of(30), 1, 5'd4, 32'hDEADBEEF, 32'h500));
        chk("lw_hold1_fwd_valid", ms_fwd_valid, 1);
        chk("lw_hold1_fwd_data", ms_fwd_data, 32'hDEADBEEF);
        chk("lw_hold1_allowin", ms_allowin, 0);
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        chk("lw_rel_valid", ms_to_ws_valid, 1);
        chk("lw_rel_bus", ms_to_ws_bus, mk_out(exb_of(30), 1, 5'd4, 32'hDEADBEEF, 32'h500));
        @(negedge clk);
        #1;
        chk("lw_once_valid", ms_to_ws_valid, 0);

        // Flush a pending LW; its late response must be discarded.
        issue(mk_bus(exb_of(40), 1, 1, 0, 2'b10, 2'd0, 1, 5'd2, 32'h0, 32'h200));
        @(negedge clk);
        es_to_ms_valid = 1'b0; ws_ex = 1'b1;
        #1;
        chk("fl_pend_load_wait", ms_load_wait, 1);
        @(negedge clk);
        ws_ex = 1'b0;
        #1;
        chk("fl_after_valid", ms_to_ws_valid, 0);
        chk("fl_after_allowin", ms_allowin, 1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(exb_of(41), 1, 1, 0, 2'b10, 2'd0, 1, 5'd2, 32'h0, 32'h204);
        @(negedge clk);
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA5555;
        #1;
        chk("fl_drop_valid", ms_to_ws_valid, 0);
        chk("fl_drop_load_wait", ms_load_wait, 1);
        @(negedge clk);
        data_sram_rdata = 32'h11223344;
        #1;
        chk("fl_new_valid", ms_to_ws_valid, 1);
        chk("fl_new_bus", ms_to_ws_bus, mk_out(exb_of(41), 1, 5'd2, 32'h11223344, 32'h204));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(exb_of(42), 0, 0, 0, 2'b00, 2'd0, 1, 5'd9, 32'h0BADF00D, 32'h208);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        chk("fl_addu_valid", ms_to_ws_valid, 1);
        chk("fl_addu_bus", ms_to_ws_bus, mk_out(exb_of(42), 1, 5'd9, 32'h0BADF00D, 32'h208));

        // Flush coincident with the response: nothing left to discard.
        issue(mk_bus(exb_of(50), 1, 1, 0, 2'b10, 2'd0, 1, 5'd1, 32'h0, 32'h300));
        @(negedge clk);
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h99999999;
        ws_ex = 1'b1;
        @(negedge clk);
        data_sram_data_ok = 1'b0; ws_ex = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(exb_of(51), 1, 1, 0, 2'b10, 2'd0, 1, 5'd1, 32'h0, 32'h304);
        #1;
        chk("co_idle_valid", ms_to_ws_valid, 0);
        @(negedge clk);
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55667788;
        #1;
        chk("co_new_valid", ms_to_ws_valid, 1);
        chk("co_new_bus", ms_to_ws_bus, mk_out(exb_of(51), 1, 5'd1, 32'h55667788, 32'h304));
        @(negedge clk);
        data_sram_data_ok = 1'b0;

        // Reset while a discard is outstanding and a load is pending.
        issue(mk_bus(exb_of(60), 1, 1, 0, 2'b10, 2'd0, 1, 5'd7, 32'h0, 32'h400));
        @(negedge clk);
        es_to_ms_valid = 1'b0; ws_ex = 1'b1;
        @(negedge clk);
        ws_ex = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(exb_of(61), 1, 1, 0, 2'b10, 2'd0, 1, 5'd7, 32'h0, 32'h404);
        @(negedge clk);
        es_to_ms_valid = 1'b0; resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("mrst_allowin",   ms_allowin, 1);
        chk("mrst_valid",     ms_to_ws_valid, 0);
        chk("mrst_load_wait", ms_load_wait, 0);
        chk("mrst_fwd_dest",  ms_fwd_dest, 0);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(exb_of(62), 1, 1, 0, 2'b10, 2'd0, 1, 5'd7, 32'h0, 32'h408);
        @(negedge clk);
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D;
        #1;
        chk("mrst_new_valid", ms_to_ws_valid, 1);
        chk("mrst_new_bus", ms_to_ws_bus, mk_out(exb_of(62), 1, 5'd7, 32'hCAFEF00D, 32'h408));
        @(negedge clk);
        data_sram_data_ok = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
